wb_lms_master: RTL and testbench

//  Wishbone master that drives the memory-mapped LMS adaptive filter peripheral from a sample stream.

---
 rtl/wb_lms_master_if.sv | 19 +
 rtl/wb_lms_master.sv | 193 +++++++++++++++++++
 tb/tb_wb_lms_master.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/wb_lms_master_if.sv
// wb_lms_master_if: Wishbone bus between wb_lms_master (master) and the wb_lms register slave (slave)
// Signals: wb_cyc_o/wb_stb_o/wb_we_o/wb_adr_o/wb_dat_o driven by master; wb_dat_i/wb_ack_i driven by slave.
interface wb_lms_master_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic        wb_ack_i;
  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );
  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_lms_master.sv
// wb_lms_master: Wishbone master pushing (x,d) samples through the wb_lms peripheral and streaming back y/err
// Ports: Clk, Rst (sync, active-high); s_valid/s_ready/s_x/s_d/mode_train sample input stream;
//        m_valid/m_ready/m_y/m_err result stream (plus m_w = {w3,w2,w1,w0} when WB_LMS_MASTER_WREAD_EN is defined);
//        busy (not idle); bus_err (sticky ack timeout); wb = master modport of wb_lms_master_if.
// Define WB_LMS_MASTER_WREAD_EN to also read weights w0..w3 (k=5..8) after err.
module wb_lms_master #(
  parameter logic [31:0] ADR_BASE = 32'h0000_0000,
  parameter int          SETTLE   = 2,
  parameter int          TIMEOUT  = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_x,
  input  logic [15:0] s_d,
  input  logic        mode_train,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_y,
  output logic [15:0] m_err,
`ifdef WB_LMS_MASTER_WREAD_EN
  output logic [63:0] m_w,
`endif
  output logic        busy,
  output logic        bus_err,
  wb_lms_master_if.master wb
);
  typedef enum logic [3:0] {
    IDLE, WR_MODE, WR_X, WR_D, SETL, RD_Y, RD_E, RD_W0, RD_W1, RD_W2, RD_W3, OUT
  } state_t;
  state_t      state_q, state_d, nxt;
  logic        stb_q, stb_d, we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [15:0] dat_q, dat_d, x_q, x_d, d_q, d_d, y_q, y_d, e_q, e_d;
  logic        mode_q, mode_d, last_q, last_d, known_q, known_d;
  logic        s_ready_q, s_ready_d, m_valid_q, m_valid_d, busy_q, busy_d, bus_err_q, bus_err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  k;
  logic        wr, xfer;
`ifdef WB_LMS_MASTER_WREAD_EN
  logic [63:0] w_q, w_d;
  assign m_w = w_q;
`endif
  always_comb begin
    wr   = state_q inside {WR_MODE, WR_X, WR_D};
    xfer = !(state_q inside {IDLE, SETL, OUT});
    k = state_q == WR_MODE ? 4'd2 :
        state_q == WR_X    ? 4'd0 :
        state_q == WR_D    ? 4'd1 :
        state_q == RD_Y    ? 4'd3 :
        state_q == RD_E    ? 4'd4 :
        state_q == RD_W0   ? 4'd5 :
        state_q == RD_W1   ? 4'd6 :
        state_q == RD_W2   ? 4'd7 : 4'd8;
    nxt = state_q == WR_MODE ? WR_X :
          state_q == WR_X    ? WR_D :
          state_q == WR_D    ? (SETTLE == 0 ? RD_Y : SETL) :
          state_q == RD_Y    ? RD_E :
`ifdef WB_LMS_MASTER_WREAD_EN
          state_q == RD_E    ? RD_W0 :
          state_q == RD_W0   ? RD_W1 :
          state_q == RD_W1   ? RD_W2 :
          state_q == RD_W2   ? RD_W3 :
`endif
          OUT;
    state_d   = state_q;
    stb_d     = stb_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    x_d       = x_q;
    d_d       = d_q;
    y_d       = y_q;
    e_d       = e_q;
    mode_d    = mode_q;
    last_d    = last_q;
    known_d   = known_q;
    bus_err_d = bus_err_q;
    cnt_d     = cnt_q;
`ifdef WB_LMS_MASTER_WREAD_EN
    w_d       = w_q;
`endif
    if (state_q == IDLE) begin
      if (s_valid && s_ready_q) begin
        x_d     = s_x;
        d_d     = s_d;
        mode_d  = mode_train;
        state_d = (!known_q || mode_train != last_q) ? WR_MODE : WR_X;
      end
    end else if (state_q == SETL) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_q == 8'(SETTLE - 1)) begin
        cnt_d   = 8'd0;
        state_d = RD_Y;
      end
    end else if (state_q == OUT) begin
      if (m_ready) state_d = IDLE;
    end else if (xfer && !stb_q) begin
      // one idle bus cycle before every strobe: the slave acks for exactly one cycle
      stb_d = 1'b1;
      cnt_d = 8'd0;
      we_d  = wr;
      adr_d = ADR_BASE + {26'b0, k, 2'b00};
      dat_d = state_q == WR_MODE ? {15'b0, mode_q} :
              state_q == WR_X    ? x_q :
              state_q == WR_D    ? d_q : 16'h0000;
    end else if (wb.wb_ack_i) begin
      stb_d   = 1'b0;
      cnt_d   = 8'd0;
      state_d = nxt;
      if (state_q == WR_MODE) begin
        known_d = 1'b1;
        last_d  = mode_q;
      end
      if (state_q == RD_Y) y_d = wb.wb_dat_i;
      if (state_q == RD_E) e_d = wb.wb_dat_i;
`ifdef WB_LMS_MASTER_WREAD_EN
      if (state_q == RD_W0) w_d[15:0]  = wb.wb_dat_i;
      if (state_q == RD_W1) w_d[31:16] = wb.wb_dat_i;
      if (state_q == RD_W2) w_d[47:32] = wb.wb_dat_i;
      if (state_q == RD_W3) w_d[63:48] = wb.wb_dat_i;
`endif
    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
      // abort: the peripheral's mode is now unknown, so force a rewrite next time
      stb_d     = 1'b0;
      bus_err_d = 1'b1;
      known_d   = 1'b0;
      state_d   = IDLE;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    s_ready_d = state_d == IDLE;
    m_valid_d = state_d == OUT;
    busy_d    = state_d != IDLE;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= 32'h0;
      dat_q     <= 16'h0;
      x_q       <= 16'h0;
      d_q       <= 16'h0;
      y_q       <= 16'h0;
      e_q       <= 16'h0;
      mode_q    <= 1'b0;
      last_q    <= 1'b0;
      known_q   <= 1'b0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      bus_err_q <= 1'b0;
      cnt_q     <= 8'd0;
`ifdef WB_LMS_MASTER_WREAD_EN
      w_q       <= 64'h0;
`endif
    end else begin
      state_q   <= state_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      x_q       <= x_d;
      d_q       <= d_d;
      y_q       <= y_d;
      e_q       <= e_d;
      mode_q    <= mode_d;
      last_q    <= last_d;
      known_q   <= known_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      busy_q    <= busy_d;
      bus_err_q <= bus_err_d;
      cnt_q     <= cnt_d;
`ifdef WB_LMS_MASTER_WREAD_EN
      w_q       <= w_d;
`endif
    end
  end
  assign s_ready     = s_ready_q;
  assign m_valid     = m_valid_q;
  assign m_y         = y_q;
  assign m_err       = e_q;
  assign busy        = busy_q;
  assign bus_err     = bus_err_q;
  assign wb.wb_cyc_o = stb_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
endmodule

// File: tb/tb_wb_lms_master.sv
// tb_wb_lms_master: directed table-driven bench for wb_lms_master with a one-cycle-ack Wishbone slave model
module tb_wb_lms_master;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int SETTLE = 2;
  localparam int TIMEOUT = 16;
`ifdef WB_LMS_MASTER_WREAD_EN
  localparam int NW = 4;
`else
  localparam int NW = 0;
`endif
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic s_valid = 1'b0, s_ready, mode_train = 1'b0;
  logic [15:0] s_x = 16'h0, s_d = 16'h0, m_y, m_err;
  logic m_valid, m_ready = 1'b0, busy, bus_err;
`ifdef WB_LMS_MASTER_WREAD_EN
  logic [63:0] m_w;
`endif
  int total = 0, passed = 0;
  always #5 Clk = ~Clk;
  wb_lms_master_if wb();
  wb_lms_master #(.ADR_BASE(BASE), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst(Rst), .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_d(s_d),
    .mode_train(mode_train), .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_err(m_err),
`ifdef WB_LMS_MASTER_WREAD_EN
    .m_w(m_w),
`endif
    .busy(busy), .bus_err(bus_err), .wb(wb)
  );
  typedef struct packed {logic we; logic [31:0] adr; logic [15:0] dat;} xfer_t;
  typedef struct {logic [15:0] x, d, y, e; logic mode, mw;} sample_t;
  logic [15:0] y_r = 16'h0, e_r = 16'h0;
  logic no_ack_y = 1'b0;
  logic [3:0] k;
  xfer_t log_q[$];
  logic prev_ack = 1'b0, prev_stb = 1'b0;
  logic [48:0] prev_bus = '0;
  int gap_viol = 0, stab_viol = 0, run = 0, last_run = 0;
  assign k = wb.wb_adr_o[5:2];
  always @(posedge Clk) begin
    if (Rst) wb.wb_ack_i <= 1'b0;
    else wb.wb_ack_i <= wb.wb_stb_o && !wb.wb_ack_i && !(no_ack_y && k == 4'd3);
    wb.wb_dat_i <= k == 4'd3 ? y_r : k == 4'd4 ? e_r :
                   (k >= 4'd5 && k <= 4'd8) ? {12'h0, k} - 16'd4 : 16'h0;
    if (wb.wb_stb_o && wb.wb_ack_i)
      log_q.push_back(xfer_t'({wb.wb_we_o, wb.wb_adr_o, wb.wb_we_o ? wb.wb_dat_o : wb.wb_dat_i}));
    if (wb.wb_stb_o && prev_ack) gap_viol <= gap_viol + 1;
    if ((wb.wb_stb_o && prev_stb && {wb.wb_we_o, wb.wb_adr_o, wb.wb_dat_o} != prev_bus) ||
        wb.wb_stb_o != wb.wb_cyc_o) stab_viol <= stab_viol + 1;
    prev_ack <= wb.wb_stb_o && wb.wb_ack_i;
    prev_stb <= wb.wb_stb_o;
    prev_bus <= {wb.wb_we_o, wb.wb_adr_o, wb.wb_dat_o};
    if (wb.wb_stb_o) run <= run + 1;
    else if (run != 0) begin
      last_run <= run;
      run <= 0;
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask
  task automatic accept(input sample_t s);
    @(negedge Clk);
    y_r = s.y;
    e_r = s.e;
    chk("s_ready_idle", s_ready, 1);
    s_x = s.x;
    s_d = s.d;
    mode_train = s.mode;
    s_valid = 1'b1;
    @(posedge Clk);
    #1 s_valid = 1'b0;
  endtask
  task automatic run_sample(input sample_t s);
    int base, n;
    xfer_t exp_l[$];
    accept(s);
    base = log_q.size() - 0;
    n = 0;
    while (!m_valid && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("latency", n, 12 + 3 * NW + SETTLE + 1 + (s.mw ? 3 : 0));
    chk("m_y", m_y, s.y);
    chk("m_err", m_err, s.e);
    if (s.mw) exp_l.push_back(xfer_t'({1'b1, BASE + 32'd8, 15'b0, s.mode}));
    exp_l.push_back(xfer_t'({1'b1, BASE, s.x}));
    exp_l.push_back(xfer_t'({1'b1, BASE + 32'd4, s.d}));
    exp_l.push_back(xfer_t'({1'b0, BASE + 32'd12, s.y}));
    exp_l.push_back(xfer_t'({1'b0, BASE + 32'd16, s.e}));
    for (int j = 0; j < NW; j++)
      exp_l.push_back(xfer_t'({1'b0, BASE + 32'd20 + 32'(4 * j), 16'(j + 1)}));
    chk("xfer_count", log_q.size() - base, exp_l.size());
    for (int i = 0; i < exp_l.size(); i++)
      if (base + i < log_q.size()) chk("xfer", log_q[base + i], exp_l[i]);
`ifdef WB_LMS_MASTER_WREAD_EN
    chk("m_w", m_w, 64'h0004_0003_0002_0001);
`endif
    m_ready = 1'b1;
    @(negedge Clk);
    m_ready = 1'b0;
    chk("m_valid_drop", m_valid, 0);
    chk("busy_idle", busy, 0);
  endtask
  initial begin
    sample_t tv[5];
    sample_t s;
    int n, bad;
    logic saw;
    logic [15:0] sy, se;
    tv[0] = '{x:16'h0100, d:16'h0200, y:16'h1234, e:16'h8765, mode:1'b1, mw:1'b1};
    tv[1] = '{x:16'hffff, d:16'h8000, y:16'h7fff, e:16'h0001, mode:1'b1, mw:1'b0};
    tv[2] = '{x:16'h0003, d:16'hfffd, y:16'hfff0, e:16'h000d, mode:1'b0, mw:1'b1};
    tv[3] = '{x:16'h0000, d:16'h0000, y:16'h0000, e:16'h0000, mode:1'b0, mw:1'b0};
    tv[4] = '{x:16'h8000, d:16'h7fff, y:16'hdead, e:16'hbeef, mode:1'b1, mw:1'b1};
    repeat (3) @(negedge Clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_cyc", {wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o}, 0);
    chk("rst_data", {m_y, m_err, wb.wb_adr_o, wb.wb_dat_o}, 0);
    Rst = 1'b0;
    for (int i = 0; i < 5; i++) run_sample(tv[i]);
    s = '{x:16'h0011, d:16'h0022, y:16'h0033, e:16'h0044, mode:1'b1, mw:1'b0};
    no_ack_y = 1'b1;
    accept(s);
    n = 0;
    saw = 1'b0;
    while (!bus_err && n < 200) begin
      @(negedge Clk);
      n++;
      saw |= m_valid;
    end
    @(negedge Clk);
    no_ack_y = 1'b0;
    chk("to_bus_err", bus_err, 1);
    chk("to_stb_len", last_run, TIMEOUT);
    chk("to_no_m_valid", saw, 0);
    chk("to_idle", {busy, s_ready}, 2'b01);
    run_sample('{x:16'h0055, d:16'h0066, y:16'h0077, e:16'h0088, mode:1'b1, mw:1'b1});
    s = '{x:16'h1111, d:16'h2222, y:16'h3333, e:16'h4444, mode:1'b1, mw:1'b0};
    accept(s);
    n = 0;
    while (!m_valid && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("hold_m_valid", m_valid, 1);
    sy = m_y;
    se = m_err;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (!m_valid || m_y !== sy || m_err !== se || s_ready || wb.wb_stb_o || wb.wb_cyc_o) bad++;
    end
    chk("hold_stable", bad, 0);
    chk("hold_m_y", m_y, 16'h3333);
    chk("hold_m_err", m_err, 16'h4444);
    m_ready = 1'b1;
    @(negedge Clk);
    m_ready = 1'b0;
    chk("hold_release", m_valid, 0);
    chk("bus_err_sticky", bus_err, 1);
    s = '{x:16'h0abc, d:16'h0def, y:16'h0001, e:16'h0002, mode:1'b0, mw:1'b1};
    accept(s);
    n = 0;
    while (!(wb.wb_stb_o && wb.wb_we_o && wb.wb_adr_o == BASE + 32'd4) && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("reach_wr_d", n < 100, 1);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("rst_mid_cyc", {wb.wb_cyc_o, wb.wb_stb_o}, 0);
    chk("rst_mid_s_ready", s_ready, 1);
    chk("rst_mid_m_valid", m_valid, 0);
    chk("rst_mid_bus_err", bus_err, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (m_valid || wb.wb_stb_o || busy) bad++;
    end
    chk("rst_mid_quiet", bad, 0);
    run_sample('{x:16'h0f0f, d:16'hf0f0, y:16'h5a5a, e:16'ha5a5, mode:1'b0, mw:1'b1});
    chk("bus_gap", gap_viol, 0);
    chk("bus_stable", stab_viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
